control_seq: RTL and testbench

Sequential successor to the combinational control decoder. It owns the instruction cycle phase internally instead of taking `cycle` as an input, and inserts a configurable number of memory wait states plus a mem_ready handshake for two-cycle memory/jump instructions (inst[7]=1). It also adds a halt request honoured at instruction boundaries. It sits between the instruction register and the datapath/memory strobes.

---
 rtl/control_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_control_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// control_seq: sequential control decoder with an internal instruction phase,
// memory wait states, a mem_ready handshake and halt at instruction boundaries.
// Optional stall cycle counter output enabled by the CONTROL_STALL_CNT_EN macro.
module control_seq #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inst,
  input  logic       carry,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       cycle,
  output logic       inst_latch,
  output logic       halted,
  output logic       M,
  output logic       S,
  output logic       J,
  output logic       LJ,
  output logic       CLI,
  output logic       LJR,
  output logic       MW,
  output logic       MC,
  output logic       RD,
  output logic       WR,
  output logic       Y,
  output logic       WA,
  output logic       ISP,
  output logic       WC,
  output logic [1:0] RS,
  output logic [3:0] ALU,
  output logic [7:0] SIG
`ifdef CONTROL_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_PH0  = 2'd0,
    ST_WAIT = 2'd1,
    ST_PH1  = 2'd2,
    ST_HALT = 2'd3
  } stateT;

  localparam logic [CNT_W-1:0] memWaitC = CNT_W'(MEM_WAIT);
  localparam logic             noWaitC  = (MEM_WAIT == 0);

  stateT            stateR;
  stateT            nextStateS;
  logic [CNT_W-1:0] waitCntR;
  logic [CNT_W-1:0] nextCntS;
  logic [CNT_W-1:0] cntDecS;
  logic             cycleS;

  logic decM, decS, decJ, decLJ, decCLI, decLJR, decMW, decMC;
  logic decRD, decWR, decY, decWA, decISP, decWC, decX;
  logic [3:0] decAlu;
  logic [7:0] decSig;

  // State and wait counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR   <= ST_PH0;
      waitCntR <= {CNT_W{1'b0}};
    end else begin
      stateR   <= nextStateS;
      waitCntR <= nextCntS;
    end
  end

  // The WAIT exit test looks at the already-decremented count, so an
  // instruction spends exactly MEM_WAIT cycles in WAIT when memory is ready.
  assign cntDecS = (waitCntR == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (waitCntR - {{(CNT_W-1){1'b0}}, 1'b1});
  assign cycleS  = (stateR == ST_PH1);

  // Next-state and wait counter update.
  always_comb begin
    nextStateS = stateR;
    nextCntS   = waitCntR;
    case (stateR)
      ST_PH0: begin
        if (inst[7]) begin
          if (noWaitC && mem_ready) begin
            nextStateS = ST_PH1;
          end else begin
            nextStateS = ST_WAIT;
            nextCntS   = memWaitC;
          end
        end else if (halt_req) begin
          nextStateS = ST_HALT;
        end else begin
          nextStateS = ST_PH0;
        end
      end
      ST_WAIT: begin
        nextCntS = cntDecS;
        if ((cntDecS == {CNT_W{1'b0}}) && mem_ready) begin
          nextStateS = ST_PH1;
        end else begin
          nextStateS = ST_WAIT;
        end
      end
      ST_PH1: begin
        if (halt_req) begin
          nextStateS = ST_HALT;
        end else begin
          nextStateS = ST_PH0;
        end
      end
      ST_HALT: begin
        if (halt_req) begin
          nextStateS = ST_HALT;
        end else begin
          nextStateS = ST_PH0;
        end
      end
      default: begin
        nextStateS = ST_PH0;
        nextCntS   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Raw instruction decode using the internal phase as the cycle bit.
  always_comb begin
    decM   = inst[7] & ~inst[6] & cycleS;
    decS   = inst[4];
    decJ   = inst[7] & inst[6] & inst[5] & cycleS & ~(carry & inst[4]);
    decLJ  = ~inst[7] & ~inst[6] & ~inst[5] & inst[4] & ~inst[3];
    decCLI = decLJ & inst[1];
    decLJR = decLJ & inst[2];
    decMW  = decM & inst[5];
    decMC  = inst[7] & ~cycleS;
    decRD  = ~inst[7] & ~inst[6] & ~inst[5] & ~inst[4] & inst[2];
    decWR  = ~inst[7] & ~inst[6] & ~inst[5] & ~inst[4] & inst[3];
    decY   = inst[5];
    decISP = ~inst[7] & ~inst[6] & inst[5];
    decX   = (inst[6] & ~inst[7]) | (cycleS & inst[6] & ~inst[5]);
    decWA  = (decM & ~inst[5]) | (decX & ~(inst[4] & ~inst[3]));
    decWC  = (decX | decISP) & inst[4];
    if (inst[6]) begin
      decAlu = inst[3:0];
    end else begin
      decAlu = {~inst[7], 3'b000};
    end
    if (~inst[7] & ~inst[6] & ~inst[5] & inst[4] & inst[3]) begin
      decSig = 8'd1 << inst[2:0];
    end else begin
      decSig = 8'd0;
    end
  end

  // Phase gating of the decode onto the output strobes.
  always_comb begin
    cycle      = cycleS;
    inst_latch = 1'b0;
    halted     = 1'b0;
    M          = 1'b0;
    S          = 1'b0;
    J          = 1'b0;
    LJ         = 1'b0;
    CLI        = 1'b0;
    LJR        = 1'b0;
    MW         = 1'b0;
    MC         = 1'b0;
    RD         = 1'b0;
    WR         = 1'b0;
    Y          = 1'b0;
    WA         = 1'b0;
    ISP        = 1'b0;
    WC         = 1'b0;
    SIG        = 8'd0;
    RS         = inst[1:0];
    ALU        = decAlu;
    case (stateR)
      ST_PH0, ST_PH1: begin
        inst_latch = cycleS | ~inst[7];
        M          = decM;
        S          = decS;
        J          = decJ;
        LJ         = decLJ;
        CLI        = decCLI;
        LJR        = decLJR;
        MW         = decMW;
        MC         = decMC;
        RD         = decRD;
        WR         = decWR;
        Y          = decY;
        WA         = decWA;
        ISP        = decISP;
        WC         = decWC;
        SIG        = decSig;
      end
      ST_WAIT: begin
        MC = 1'b1;
        Y  = decY;
        S  = decS;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

`ifdef CONTROL_STALL_CNT_EN
  logic [15:0] stallCntR;

  // Saturating count of cycles spent in WAIT or HALT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCntR <= 16'd0;
    end else if (((stateR == ST_WAIT) || (stateR == ST_HALT)) && (stallCntR != 16'hFFFF)) begin
      stallCntR <= stallCntR + 16'd1;
    end else begin
      stallCntR <= stallCntR;
    end
  end

  assign stall_cnt = stallCntR;
`endif

endmodule

// File: tb/tb_control_seq.sv
// Directed self-checking bench for control_seq: three instances with
// MEM_WAIT = 0, 2 and (with CONTROL_STALL_CNT_EN) 3 share one stimulus set.
module tb_control_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] inst;
  logic       carry;
  logic       memReady;
  logic       haltReq;

  // Strobe vector order: {M,S,J,LJ,CLI,LJR,MW,MC,RD,WR,Y,WA,ISP,WC}
  wire [13:0] stb0, stb2, stb3;
  wire        cyc0, lat0, hlt0, cyc2, lat2, hlt2, cyc3, lat3, hlt3;
  wire [1:0]  rs0, rs2, rs3;
  wire [3:0]  alu0, alu2, alu3;
  wire [7:0]  sig0, sig2, sig3;
`ifdef CONTROL_STALL_CNT_EN
  wire [15:0] stall0, stall2, stall3;
`endif

  int checkCnt = 0;
  int passCnt  = 0;

  logic [7:0]  vecInst [8];
  logic [13:0] vecStb  [8];
  logic [7:0]  vecSig  [8];
  logic [3:0]  vecAlu  [8];

  always #5 clk = ~clk;

  control_seq #(.MEM_WAIT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .inst(inst), .carry(carry), .mem_ready(memReady), .halt_req(haltReq),
    .cycle(cyc0), .inst_latch(lat0), .halted(hlt0),
    .M(stb0[13]), .S(stb0[12]), .J(stb0[11]), .LJ(stb0[10]), .CLI(stb0[9]), .LJR(stb0[8]), .MW(stb0[7]),
    .MC(stb0[6]), .RD(stb0[5]), .WR(stb0[4]), .Y(stb0[3]), .WA(stb0[2]), .ISP(stb0[1]), .WC(stb0[0]),
    .RS(rs0), .ALU(alu0), .SIG(sig0)
`ifdef CONTROL_STALL_CNT_EN
    , .stall_cnt(stall0)
`endif
  );

  control_seq #(.MEM_WAIT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .inst(inst), .carry(carry), .mem_ready(memReady), .halt_req(haltReq),
    .cycle(cyc2), .inst_latch(lat2), .halted(hlt2),
    .M(stb2[13]), .S(stb2[12]), .J(stb2[11]), .LJ(stb2[10]), .CLI(stb2[9]), .LJR(stb2[8]), .MW(stb2[7]),
    .MC(stb2[6]), .RD(stb2[5]), .WR(stb2[4]), .Y(stb2[3]), .WA(stb2[2]), .ISP(stb2[1]), .WC(stb2[0]),
    .RS(rs2), .ALU(alu2), .SIG(sig2)
`ifdef CONTROL_STALL_CNT_EN
    , .stall_cnt(stall2)
`endif
  );

`ifdef CONTROL_STALL_CNT_EN
  control_seq #(.MEM_WAIT(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .inst(inst), .carry(carry), .mem_ready(memReady), .halt_req(haltReq),
    .cycle(cyc3), .inst_latch(lat3), .halted(hlt3),
    .M(stb3[13]), .S(stb3[12]), .J(stb3[11]), .LJ(stb3[10]), .CLI(stb3[9]), .LJR(stb3[8]), .MW(stb3[7]),
    .MC(stb3[6]), .RD(stb3[5]), .WR(stb3[4]), .Y(stb3[3]), .WA(stb3[2]), .ISP(stb3[1]), .WC(stb3[0]),
    .RS(rs3), .ALU(alu3), .SIG(sig3), .stall_cnt(stall3)
  );
`endif

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int first0;
    int first2;

    vecInst = '{8'h1D, 8'h16, 8'h04, 8'h08, 8'h30, 8'h45, 8'h5C, 8'h50};
    vecStb  = '{14'b01000000000000, 14'b01011100000000, 14'b00000000100000, 14'b00000000010000,
                14'b01000000001011, 14'b00000000000100, 14'b01000000000101, 14'b01000000000001};
    vecSig  = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecAlu  = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h5, 4'hC, 4'h0};

    // Reset behaviour with a memory instruction on the bus
    rst_n = 1'b0; inst = 8'h9F; carry = 1'b0; memReady = 1'b1; haltReq = 1'b0;
    tick();
    checkVal("rst_hold_stb", stb0, 14'b01000001000000);
    checkVal("rst_hold_cycle", cyc0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    checkVal("rst_cycle", cyc0, 1'b0);
    checkVal("rst_halted", hlt0, 1'b0);
    checkVal("rst_stb", stb0, 14'b01000001000000);
    checkVal("rst_stb_w2", stb2, 14'b01000001000000);

    // Single-cycle decode table
    doReset();
    for (int k = 0; k < 8; k++) begin
      inst = vecInst[k];
      #1;
      checkVal("tbl_stb", stb0, vecStb[k]);
      checkVal("tbl_sig", sig0, vecSig[k]);
      checkVal("tbl_alu", alu0, vecAlu[k]);
      checkVal("tbl_latch", lat0, 1'b1);
      tick();
    end

    // Two-cycle instruction without wait states
    doReset();
    inst = 8'hA3; memReady = 1'b1;
    #1;
    checkVal("a3_ph0_stb", stb0, 14'b00000001001000);
    checkVal("a3_ph0_latch", lat0, 1'b0);
    tick();
    checkVal("a3_ph1_cycle", cyc0, 1'b1);
    checkVal("a3_ph1_stb", stb0, 14'b10000010001000);
    checkVal("a3_ph1_latch", lat0, 1'b1);
    tick();
    checkVal("a3_back_cycle", cyc0, 1'b0);
    checkVal("a3_back_latch", lat0, 1'b0);

    // Wait states with mem_ready held low
    doReset();
    inst = 8'h83; memReady = 1'b0;
    #1;
    checkVal("w_ph0_stb", stb2, 14'b00000001000000);
    for (int w = 0; w < 4; w++) begin
      tick();
      checkVal("w_wait_stb", stb2, 14'b00000001000000);
      checkVal("w_wait_latch", lat2, 1'b0);
      checkVal("w_wait_rs", rs2, 2'd3);
    end
    tick();
    memReady = 1'b1;
    #1;
    checkVal("w_rise_cycle", cyc2, 1'b0);
    tick();
    checkVal("w_ph1_cycle", cyc2, 1'b1);
    checkVal("w_ph1_stb", stb2, 14'b10000000000100);
    checkVal("w_ph1_latch", lat2, 1'b1);
    tick();
    checkVal("w_done_cycle", cyc2, 1'b0);

    // Latency with mem_ready always high
    doReset();
    inst = 8'h80; memReady = 1'b1;
    first0 = -1; first2 = -1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (cyc0 && first0 < 0) first0 = e;
      if (cyc2 && first2 < 0) first2 = e;
    end
    checkVal("lat_mw0", first0, 32'd1);
    checkVal("lat_mw2", first2, 32'd3);

    // Conditional jump depends on carry, only in the data phase
    doReset();
    inst = 8'hF0; carry = 1'b1; memReady = 1'b1;
    #1;
    checkVal("j_c1_ph0", stb0, 14'b01000001001000);
    tick();
    checkVal("j_c1_ph1", stb0, 14'b01000000001000);
    tick();
    carry = 1'b0;
    #1;
    checkVal("j_c0_ph0", stb0, 14'b01000001001000);
    tick();
    checkVal("j_c0_ph1", stb0, 14'b01100000001000);
    checkVal("j_c0_cycle", cyc0, 1'b1);
    carry = 1'b0;

    // Halt during a single-cycle stream
    doReset();
    inst = 8'h45; haltReq = 1'b0;
    tick();
    checkVal("h_run_stb", stb0, 14'b00000000000100);
    haltReq = 1'b1;
    #1;
    checkVal("h_req_latch", lat0, 1'b1);
    checkVal("h_req_halted", hlt0, 1'b0);
    tick();
    checkVal("h_halted", hlt0, 1'b1);
    checkVal("h_stb", stb0, 14'd0);
    checkVal("h_latch", lat0, 1'b0);
    checkVal("h_alu", alu0, 4'h5);
    checkVal("h_rs", rs0, 2'd1);
    tick();
    checkVal("h_hold", hlt0, 1'b1);
    haltReq = 1'b0;
    #1;
    checkVal("h_release_same", hlt0, 1'b1);
    tick();
    checkVal("h_resume", hlt0, 1'b0);
    checkVal("h_resume_stb", stb0, 14'b00000000000100);

    // Halt requested mid-instruction is deferred to the boundary
    doReset();
    inst = 8'h80; memReady = 1'b1; haltReq = 1'b1;
    #1;
    checkVal("d_ph0_latch", lat2, 1'b0);
    tick();
    checkVal("d_wait1", hlt2, 1'b0);
    tick();
    checkVal("d_wait2", hlt2, 1'b0);
    tick();
    checkVal("d_ph1_latch", lat2, 1'b1);
    tick();
    checkVal("d_halted", hlt2, 1'b1);
    checkVal("d_stb", stb2, 14'd0);
    haltReq = 1'b0;
    tick();
    checkVal("d_resume", hlt2, 1'b0);

    // Reset in the middle of WAIT abandons the instruction
    doReset();
    inst = 8'h83; memReady = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; memReady = 1'b1;
    tick();
    checkVal("mr_no_ph1", cyc2, 1'b0);

`ifdef CONTROL_STALL_CNT_EN
    // Stall counter accumulates WAIT cycles and clears on reset
    doReset();
    inst = 8'h80; memReady = 1'b1;
    #1;
    checkVal("sc_zero", stall3, 16'd0);
    for (int e = 0; e < 5; e++) tick();
    checkVal("sc_one", stall3, 16'd3);
    for (int e = 0; e < 5; e++) tick();
    checkVal("sc_two", stall3, 16'd6);
    rst_n = 1'b0;
    tick();
    checkVal("sc_rst", stall3, 16'd0);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
